// File: rtl/ahb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ahb_pkg
// Description : Shared AHB definitions: HTRANS encodings, arbiter state enum
//               and master index width.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package ahb_pkg;

    // Width of a master index (supports up to four masters)
    localparam int MIDX_W = 2;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ST_PARK   = 2'b00,
        ST_BUSY   = 2'b01,
        ST_LOCKED = 2'b10
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rr_pick
// Description : Combinational round-robin select. Scans requests starting at
//               last_i+1 (mod N) and checks last_i itself last.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rr_pick
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 3
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [MIDX_W-1:0]      last_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [MIDX_W-1:0]      idx_o,
    output logic                   valid_o
);

    // First requester after the last owner wins; the owner itself comes last
    always_comb begin
        int j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            j = (int'(last_i) + i) % NUM_MASTERS;
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                idx_o      = j[MIDX_W-1:0];
                grant_o[j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ahb_master_arbiter
// Description : Round-robin AHB-Lite master arbiter with lock support,
//               maximum tenure and parking on a default master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_BEATS      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MIDX_W-1:0]      hmaster,
    output logic [MIDX_W-1:0]      hmaster_data,
    output logic                   hmastlock
);

    localparam int                     c_TEN_W   = $clog2(MAX_BEATS);
    localparam logic [c_TEN_W-1:0]     c_TEN_MAX = c_TEN_W'(MAX_BEATS - 1);
    localparam logic [MIDX_W-1:0]      c_DEF_IDX = MIDX_W'(DEFAULT_MASTER);

    arb_state_e                state_q, state_d;
    logic [NUM_MASTERS-1:0]    grant_q, grant_d;
    logic [MIDX_W-1:0]         owner_q, owner_d;
    logic [c_TEN_W-1:0]        tenure_q, tenure_d;
    logic [MIDX_W-1:0]         hmaster_q, hmaster_d;
    logic [MIDX_W-1:0]         hmaster_data_q, hmaster_data_d;
    logic                      hmastlock_q, hmastlock_d;

    logic [NUM_MASTERS-1:0]    w_pick_grant;
    logic [MIDX_W-1:0]         w_pick_idx;
    logic                      w_pick_valid;
    logic                      w_keep;
    logic                      w_others;
    logic                      w_active;
    logic                      w_handover_ok;
    logic [MIDX_W-1:0]         w_new_owner;
    logic [NUM_MASTERS-1:0]    w_new_grant;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_pick (
        .req_i   (hbusreq),
        .last_i  (owner_q),
        .grant_o (w_pick_grant),
        .idx_o   (w_pick_idx),
        .valid_o (w_pick_valid)
    );

    // Arbitration decision, tenure update and pipeline of the owner indices
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        owner_d        = owner_q;
        tenure_d       = tenure_q;
        hmaster_d      = hmaster_q;
        hmaster_data_d = hmaster_data_q;
        hmastlock_d    = hmastlock_q;

        w_others      = |(hbusreq & ~grant_q);
        w_active      = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
        // A forced handover may only land on an IDLE or NONSEQ address phase
        w_handover_ok = (htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ);

        case (state_q)
            ST_LOCKED: w_keep = hbusreq[owner_q] & hlock[owner_q];
            ST_BUSY:   w_keep = hbusreq[owner_q] &
                                ~((tenure_q == c_TEN_MAX) & w_others & w_handover_ok);
            default:   w_keep = 1'b0;
        endcase

        if (w_keep) begin
            w_new_owner = owner_q;
            w_new_grant = grant_q;
        end else if (w_pick_valid) begin
            w_new_owner = w_pick_idx;
            w_new_grant = w_pick_grant;
        end else begin
            w_new_owner = c_DEF_IDX;
            w_new_grant = '0;
            w_new_grant[DEFAULT_MASTER] = 1'b1;
        end

        if (hready) begin
            owner_d = w_new_owner;
            grant_d = w_new_grant;

            if (hlock[w_new_owner] && hbusreq[w_new_owner]) begin
                state_d = ST_LOCKED;
            end else if (hbusreq[w_new_owner]) begin
                state_d = ST_BUSY;
            end else begin
                state_d = ST_PARK;
            end

            if (w_new_grant != grant_q) begin
                tenure_d = '0;
            end else if (w_active && (tenure_q != c_TEN_MAX)) begin
                tenure_d = tenure_q + 1'b1;
            end

            hmaster_d      = owner_q;
            hmaster_data_d = hmaster_q;
            hmastlock_d    = hlock[owner_q] & hbusreq[owner_q];
        end
    end

    // State registers; reset parks the bus on the default master
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_PARK;
            grant_q        <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            owner_q        <= c_DEF_IDX;
            tenure_q       <= '0;
            hmaster_q      <= c_DEF_IDX;
            hmaster_data_q <= c_DEF_IDX;
            hmastlock_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            owner_q        <= owner_d;
            tenure_q       <= tenure_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            hmastlock_q    <= hmastlock_d;
        end
    end

    assign hgrant       = grant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;
    assign hmastlock    = hmastlock_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_ahb_master_arbiter
// Description : Self-checking bench for ahb_master_arbiter: vector table plus
//               directed multi-cycle sequences.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ahb_master_arbiter;
    import ahb_pkg::*;

    logic       clk;
    logic       reset;
    logic [2:0] hbusreq;
    logic [2:0] hlock;
    logic [1:0] htrans;
    logic       hready;
    logic [2:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;
    logic       hmastlock;

    int n_checks = 0;
    int n_errors = 0;

    ahb_master_arbiter #(
        .NUM_MASTERS    (3),
        .DEFAULT_MASTER (0),
        .MAX_BEATS      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hbusreq      (hbusreq),
        .hlock        (hlock),
        .htrans       (htrans),
        .hready       (hready),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data),
        .hmastlock    (hmastlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic [2:0] lock;
        logic [1:0] trans;
        logic       rdy;
        logic [2:0] g;
        logic [1:0] hm;
        logic [1:0] hd;
        logic       ml;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [2:0] req, logic [2:0] lock, logic [1:0] trans,
                                logic rdy, logic [2:0] g, logic [1:0] hm,
                                logic [1:0] hd, logic ml);
        vec_t v;
        v.req = req; v.lock = lock; v.trans = trans; v.rdy = rdy;
        v.g = g; v.hm = hm; v.hd = hd; v.ml = ml;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        hbusreq = '0;
        hlock   = '0;
        htrans  = HTRANS_IDLE;
        hready  = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int         chg_cnt;
        int         chg_t [4];
        logic [2:0] chg_g [4];
        logic [2:0] prev_g;
        int         bad;

        // idx   req     lock    trans          rdy  grant   hm  hd  lock
        vecs[0]  = mk(3'b000, 3'b000, HTRANS_IDLE,   1, 3'b001, 0, 0, 0);
        vecs[1]  = mk(3'b010, 3'b000, HTRANS_IDLE,   1, 3'b010, 0, 0, 0);
        vecs[2]  = mk(3'b010, 3'b000, HTRANS_IDLE,   1, 3'b010, 1, 0, 0);
        vecs[3]  = mk(3'b010, 3'b000, HTRANS_NONSEQ, 1, 3'b010, 1, 1, 0);
        vecs[4]  = mk(3'b000, 3'b000, HTRANS_IDLE,   1, 3'b001, 1, 1, 0);
        vecs[5]  = mk(3'b000, 3'b000, HTRANS_IDLE,   1, 3'b001, 0, 1, 0);
        vecs[6]  = mk(3'b000, 3'b000, HTRANS_IDLE,   1, 3'b001, 0, 0, 0);
        vecs[7]  = mk(3'b100, 3'b100, HTRANS_IDLE,   1, 3'b100, 0, 0, 0);
        vecs[8]  = mk(3'b100, 3'b100, HTRANS_IDLE,   1, 3'b100, 2, 0, 1);
        vecs[9]  = mk(3'b100, 3'b100, HTRANS_IDLE,   1, 3'b100, 2, 2, 1);
        vecs[10] = mk(3'b101, 3'b000, HTRANS_IDLE,   1, 3'b001, 2, 2, 0);
        vecs[11] = mk(3'b101, 3'b000, HTRANS_IDLE,   1, 3'b001, 0, 2, 0);
        vecs[12] = mk(3'b001, 3'b000, HTRANS_IDLE,   1, 3'b001, 0, 0, 0);
        vecs[13] = mk(3'b000, 3'b000, HTRANS_IDLE,   1, 3'b001, 0, 0, 0);
        vecs[14] = mk(3'b110, 3'b000, HTRANS_IDLE,   1, 3'b010, 0, 0, 0);
        vecs[15] = mk(3'b100, 3'b000, HTRANS_IDLE,   1, 3'b100, 1, 0, 0);
        vecs[16] = mk(3'b110, 3'b000, HTRANS_IDLE,   1, 3'b100, 2, 1, 0);
        vecs[17] = mk(3'b011, 3'b000, HTRANS_IDLE,   1, 3'b001, 2, 2, 0);
        vecs[18] = mk(3'b000, 3'b000, HTRANS_IDLE,   1, 3'b001, 0, 2, 0);
        vecs[19] = mk(3'b000, 3'b000, HTRANS_IDLE,   1, 3'b001, 0, 0, 0);
        vecs[20] = mk(3'b010, 3'b000, HTRANS_IDLE,   0, 3'b001, 0, 0, 0);
        vecs[21] = mk(3'b010, 3'b000, HTRANS_IDLE,   1, 3'b010, 0, 0, 0);
        vecs[22] = mk(3'b000, 3'b000, HTRANS_IDLE,   1, 3'b001, 1, 0, 0);
        vecs[23] = mk(3'b000, 3'b000, HTRANS_IDLE,   1, 3'b001, 0, 1, 0);
        vecs[24] = mk(3'b000, 3'b000, HTRANS_IDLE,   1, 3'b001, 0, 0, 0);

        // Reset state
        do_reset();
        check("rst_hgrant", int'(hgrant), 1);
        check("rst_hmaster", int'(hmaster), 0);
        check("rst_hmaster_data", int'(hmaster_data), 0);
        check("rst_hmastlock", int'(hmastlock), 0);
        check("rst_state", int'(dut.state_q), int'(ST_PARK));

        // Vector table
        for (int i = 0; i < NV; i++) begin
            hbusreq = vecs[i].req;
            hlock   = vecs[i].lock;
            htrans  = vecs[i].trans;
            hready  = vecs[i].rdy;
            step();
            check($sformatf("v%0d_hgrant", i), int'(hgrant), int'(vecs[i].g));
            check($sformatf("v%0d_hmaster", i), int'(hmaster), int'(vecs[i].hm));
            check($sformatf("v%0d_hmaster_data", i), int'(hmaster_data), int'(vecs[i].hd));
            check($sformatf("v%0d_hmastlock", i), int'(hmastlock), int'(vecs[i].ml));
        end

        // Tenure rotation: owner 0 established, then all three request
        do_reset();
        hbusreq = 3'b001;
        step();
        check("rr_setup_grant", int'(hgrant), 1);
        hbusreq = 3'b111;
        htrans  = HTRANS_NONSEQ;
        chg_cnt = 0;
        prev_g  = hgrant;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (hgrant != prev_g) begin
                if (chg_cnt < 4) begin
                    chg_t[chg_cnt] = k;
                    chg_g[chg_cnt] = hgrant;
                end
                chg_cnt++;
                prev_g = hgrant;
            end
            if (k == 17) check("rr_hmaster_after_first", int'(hmaster), 1);
        end
        check("rr_change_count", chg_cnt, 3);
        check("rr_t0", chg_t[0], 16);
        check("rr_g0", int'(chg_g[0]), 2);
        check("rr_t1", chg_t[1], 32);
        check("rr_g1", int'(chg_g[1]), 4);
        check("rr_t2", chg_t[2], 48);
        check("rr_g2", int'(chg_g[2]), 1);

        // Expired tenure during a SEQ run must not split the burst
        htrans = HTRANS_SEQ;
        bad = 0;
        for (int k = 51; k <= 70; k++) begin
            step();
            if (hgrant != 3'b001) bad++;
        end
        check("seq_no_split", bad, 0);
        htrans = HTRANS_NONSEQ;
        step();
        check("seq_end_handover", int'(hgrant), 2);

        // Locked master 2 holds the bus for 40 beats
        do_reset();
        hbusreq = 3'b100;
        hlock   = 3'b100;
        step();
        check("lock_setup_grant", int'(hgrant), 4);
        hbusreq = 3'b111;
        htrans  = HTRANS_NONSEQ;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (hgrant != 3'b100 || hmastlock != 1'b1) bad++;
        end
        check("lock_40_beats", bad, 0);
        check("lock_state", int'(dut.state_q), int'(ST_LOCKED));
        hlock = 3'b000;
        step();
        check("lock_release_grant", int'(hgrant), 1);

        // hready low during a handover freezes everything
        do_reset();
        hbusreq = 3'b010;
        step();
        htrans = HTRANS_NONSEQ;
        step();
        step();
        step();
        check("ws_pre_tenure", int'(dut.tenure_q), 3);
        check("ws_pre_hmaster", int'(hmaster), 1);
        hbusreq = 3'b001;
        hready  = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (hgrant != 3'b010 || hmaster != 2'd1 || hmaster_data != 2'd1 ||
                dut.tenure_q != 4'd3) bad++;
        end
        check("ws_frozen", bad, 0);
        hready = 1'b1;
        step();
        check("ws_handover_grant", int'(hgrant), 1);
        check("ws_handover_tenure", int'(dut.tenure_q), 0);
        step();
        check("ws_handover_hmaster", int'(hmaster), 0);

        // Asynchronous reset in the middle of a SEQ burst owned by master 1
        do_reset();
        hbusreq = 3'b010;
        step();
        htrans = HTRANS_NONSEQ;
        step();
        htrans = HTRANS_SEQ;
        step();
        step();
        check("ar_pre_hmaster", int'(hmaster), 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_hgrant", int'(hgrant), 1);
        check("ar_hmaster", int'(hmaster), 0);
        check("ar_hmaster_data", int'(hmaster_data), 0);
        check("ar_hmastlock", int'(hmastlock), 0);
        check("ar_state", int'(dut.state_q), int'(ST_PARK));
        hbusreq = 3'b000;
        htrans  = HTRANS_IDLE;
        step();
        reset = 1'b0;
        step();
        check("ar_idle_grant", int'(hgrant), 1);
        hbusreq = 3'b010;
        step();
        check("ar_restart_grant", int'(hgrant), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Round-robin bus arbiter that shares the single AHB-Lite slave path between the three master ports (master 1..3, indices 0..2) of the multi-master AHB design. It grants the address bus to one requester at a time and drives the master-select lines used by the address/write-data muxes. It honours locked sequences and enforces a maximum tenure so that no master starves the others. Without requests the bus parks on a default master.

## Interface
- `NUM_MASTERS`, 3: number of requesting masters; the block is verified at 3.
- `DEFAULT_MASTER`, 0: master that is granted when no request is pending (parking).
- `MAX_BEATS`, 16: maximum active beats (NONSEQ/SEQ) per tenure before a forced handover; must be ≥2.
- `clk`  in  1  bus clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `hbusreq`  in  NUM_MASTERS  per-master bus request, held by the master until it is done.
- `hlock`  in  NUM_MASTERS  per-master lock request, qualified by the matching `hbusreq`.
- `htrans`  in  2  HTRANS of the current address phase on the shared bus (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- `hready`  in  1  HREADY returned by the slave mux.
- `hgrant`  out  NUM_MASTERS  one-hot grant, registered.
- `hmaster`  out  2  index of the address-phase owner; drives the address/control mux.
- `hmaster_data`  out  2  index of the data-phase owner; drives the HWDATA mux and routes HRDATA/HRESP.
- `hmastlock`  out  1  the current address phase belongs to a locked sequence.

## Operation
- States:
  - PARK: the default master is granted and nothing is requested.
  - BUSY: a requester owns the bus.
  - LOCKED: the owner holds `hlock` together with `hbusreq`.
- The arbitration point is any rising edge with `hready`=1. With `hready`=0, all registers hold, including the tenure counter.
- At an arbitration point the next owner is computed as follows:
  - LOCKED: the owner is kept while `hbusreq[o]` and `hlock[o]` stay high; tenure is ignored.
  - BUSY: the owner is kept while `hbusreq[o]`=1 and not (tenure = MAX_BEATS-1, another request is pending, and `htrans` is IDLE or NONSEQ). A forced handover never splits a SEQ run.
  - Otherwise the block scans round-robin starting at o+1 mod N, then o+2, and so on. The current owner is checked last.
  - With no request at all, the grant goes to DEFAULT_MASTER and the state moves to PARK.
- Next state is LOCKED if `hlock[new]` and `hbusreq[new]` are both high, BUSY if `hbusreq[new]` alone is high, and PARK otherwise.
- Tenure counter:
  - Width is clog2(MAX_BEATS).
  - It clears on any grant change.
  - It increments on an `hready` edge when `htrans` is NONSEQ or SEQ, and saturates at MAX_BEATS-1.
- On an `hready` edge:
  - `hmaster` takes the index of the current `hgrant`.
  - `hmaster_data` takes the old `hmaster`.
  - `hmastlock` takes `hlock[granted] & hbusreq[granted]`.
- Requests from a master that deasserts `hbusreq` before being granted are dropped silently.

## Timing
- Reset values:
  - `hgrant` = one-hot DEFAULT_MASTER.
  - `hmaster` = `hmaster_data` = DEFAULT_MASTER.
  - `hmastlock` = 0.
  - State PARK, tenure 0.
- Latency from a request to ownership, on an idle bus with `hready`=1:
  - `hbusreq` is sampled at edge N.
  - `hgrant` changes at edge N.
  - `hmaster` changes at edge N+1, so the master's first address phase is in the cycle after N+1.
  - `hmaster_data` follows at edge N+2.
- Wait states extend every stage one-for-one.
- Simultaneous requests are resolved by round-robin order only; there is no fixed priority.
- Reset mid-transfer returns all outputs to their reset values immediately, asynchronously. No pending request is remembered.

## Structure
- Shared package `ahb_pkg`: the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), the state enum (PARK/BUSY/LOCKED), and the master index width.
- One natural sub-module, `rr_pick`: combinational round-robin select taking a request vector and a last owner, returning a one-hot grant and an index. Everything else stays flat in the top module.

## Test plan
- Reset, then no requests → `hgrant`=001, `hmaster`=0, `hmastlock`=0, state PARK.
- `hbusreq`=010 with `hready`=1 → `hgrant`=010 after 1 edge, `hmaster`=1 after 2, `hmaster_data`=1 after 3.
- `hbusreq`=111 held with owner 0 and single NONSEQ beats → owner sequence 0,1,2,0, each holding exactly 16 beats.
- Master 2 with `hlock`=1 and `hbusreq`=111 for 40 beats → grant stays 100 and `hmastlock`=1 throughout; rotation to master 0 only after `hlock[2]` drops.
- `hready`=0 for 5 cycles during a handover → `hgrant`, `hmaster`, `hmaster_data` and tenure are all frozen; the handover completes on the first `hready`=1 edge.
- Assert `reset` mid-SEQ with owner 1 → outputs return to reset values within the same cycle, and arbitration restarts from PARK.
